ltc2333_drive: RTL and testbench
================================

LTC2333_DRIVE -- requirements
Module: ltc2333_drive

Interface
REQ-001 The block SHALL have parameter CNV_HIGH, default 4: CNV high time in clk cycles (min 2).
REQ-002 The block SHALL have parameter CONV_WAIT, default 60: clk cycles from CNV fall to first SCKI edge (covers t_CONV).
REQ-003 The block SHALL have parameter SCK_HALF, default 2: SCKI half-period in clk cycles (min 1).
REQ-004 The block SHALL have parameter N_SCK, default 12: SCKI periods per conversion (12 periods give 24 DDR SDO bits).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all ports are synchronous to it.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port enable, input, 1 bit: permits starts; when low, start and free-run ticks are ignored.
REQ-008 The block SHALL have port start, input, 1 bit: single-cycle conversion request.
REQ-009 The block SHALL have port free_run, input, 1 bit: starts conversions from the internal period timer.
REQ-010 The block SHALL have port period, input, 16 bits: free-run period in clk cycles; values below 2 are treated as 2.
REQ-011 The block SHALL have port seq_cfg, input, 64 bits: eight 8-bit SDI control words; slot k occupies bits [8k+7:8k].
REQ-012 The block SHALL have port seq_len, input, 4 bits: active slot count; 0 is treated as 1, and values above 8 are treated as 8.
REQ-013 The block SHALL have port cnv, output, 1 bit: ADC CNV pin.
REQ-014 The block SHALL have port scki, output, 1 bit: ADC SCKI pin; the ADC echoes it as SCKO to the read block.
REQ-015 The block SHALL have port sdi, output, 1 bit: ADC SDI pin, carrying control words MSB first.
REQ-016 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-017 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of each conversion.
REQ-018 The block SHALL have port slot, output, 3 bits: index of the control word used by the current or most recent conversion.
REQ-019 The block SHALL have port overrun_cnt, output, 16 bits: saturating count of requests dropped because the block was busy.

Function
REQ-020 The state machine SHALL have exactly the states IDLE, CNV, CONV, SCK_LO, SCK_HI and GAP.
REQ-021 A request (start, or a free-run tick) in IDLE with enable=1 SHALL move the machine to CNV on the next edge and latch seq_cfg and seq_len.
REQ-022 In CNV, cnv SHALL be 1 for exactly CNV_HIGH cycles, after which the machine goes to CONV with cnv=0.
REQ-023 CONV SHALL last CONV_WAIT cycles, after which the machine goes to SCK_LO.
REQ-024 SCK_LO and SCK_HI SHALL each last SCK_HALF cycles, with scki=0 and scki=1 respectively; SCK_HI returns to SCK_LO until N_SCK periods are complete, then goes to GAP.
REQ-025 sdi SHALL update on entry to SCK_LO: bit 7-p of the latched word for SCKI period p=0..7, and 0 for p>=8.
REQ-026 GAP SHALL last 1 cycle and assert done; slot SHALL then advance, wrapping from latched seq_len-1 to 0, and the machine returns to IDLE.
REQ-027 A request arriving while busy=1, or simultaneous with done, SHALL be dropped and SHALL increment overrun_cnt, which saturates at 0xFFFF.
REQ-028 A start coinciding with a free-run tick SHALL count as one request.
REQ-029 When free_run=1, a tick SHALL occur every max(period,2) cycles; the timer SHALL restart on the rising edge of free_run and SHALL hold at 0 while free_run=0.
REQ-030 enable=0 SHALL NOT abort a conversion already in progress.
REQ-031 A change to seq_len mid-sequence SHALL take effect at the next start; if slot is then >= the new length, slot SHALL wrap to 0.
REQ-032 cnv, scki, sdi, busy and done SHALL be driven directly from registers (glitch-free pins).
REQ-033 Internal counters SHALL be sized by $clog2 of their parameters.
REQ-034 The total conversion length SHALL be CNV_HIGH + CONV_WAIT + 2*SCK_HALF*N_SCK + 1 cycles.

Reset
REQ-035 Reset SHALL immediately force state=IDLE and all outputs (cnv, scki, sdi, busy, done, slot, overrun_cnt) and the free-run timer to 0.
REQ-036 Reset asserted mid-conversion SHALL drop cnv and scki in the same cycle; after release, the next request SHALL start a fresh conversion at slot 0.

Structure
REQ-037 A package ltc2333_pkg SHALL hold the state enum, the 8-bit control-word struct (valid, chan[2:0], span[2:0], pad) and the default timing constants.
REQ-038 A sub-module ltc2333_period_timer SHALL implement the free-run tick generator.
REQ-039 The state machine, shift logic and counters SHALL reside in ltc2333_drive.

Verification
REQ-040 Single conversion: defaults, start pulse, seq_len=1, seq_cfg[7:0]=0xA5 -> cnv high for 4 cycles, 12 scki periods of 4 cycles each, sdi=1,0,1,0,0,1,0,1,0,0,0,0, done pulse 113 cycles after start, slot returns to 0.
REQ-041 Sequence wrap: seq_len=3, five starts spaced 200 cycles apart -> slot sequence 0,1,2,0,1, and sdi carries the matching words.
REQ-042 Overrun: start issued 50 cycles after a previous start, and again on the done cycle -> overrun_cnt=2 and only one conversion runs.
REQ-043 Free-run: period=150 for 1500 cycles -> 10 conversions, overrun_cnt=0; with period=100 -> overrun_cnt increments on every other tick.
REQ-044 Reset mid-SCK_HI -> cnv, scki, sdi and busy read 0 in the same cycle; the next start produces a full 113-cycle conversion at slot 0.
REQ-045 Clamps: seq_len=0 then seq_len=12 -> behaviour matches 1 and 8 respectively; period=0 -> a tick every 2 cycles.

Source files
------------

// File: rtl/ltc2333_pkg.sv
// ltc2333_pkg
// Shared types and default timing for the LTC2333 drive block.
//   state_t     : drive state machine states
//   ctrl_word_t : 8-bit SDI control word (valid, chan, span, pad), sent MSB first
//   DEF_*       : default timing parameters in clk cycles
//   max3        : helper used to size the shared phase counter
package ltc2333_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNV,
    CONV,
    SCK_LO,
    SCK_HI,
    GAP
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] chan;
    logic [2:0] span;
    logic       pad;
  } ctrl_word_t;

  localparam int DEF_CNV_HIGH  = 4;
  localparam int DEF_CONV_WAIT = 60;
  localparam int DEF_SCK_HALF  = 2;
  localparam int DEF_N_SCK     = 12;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ltc2333_drive_if.sv
// ltc2333_drive_if
// ADC pin bundle driven by ltc2333_drive.
//   cnv  : conversion start pin
//   scki : serial clock to the ADC (echoed back as SCKO to the read side)
//   sdi  : control-word data to the ADC
// Modports: master (the drive block), slave (the ADC / observers).
interface ltc2333_drive_if;
  logic cnv;
  logic scki;
  logic sdi;

  modport master (output cnv, output scki, output sdi);
  modport slave  (input  cnv, input  scki, input  sdi);
endinterface

// File: rtl/ltc2333_period_timer.sv
// ltc2333_period_timer
// Free-run tick generator: o_tick pulses every max(i_period, 2) cycles while
// i_free_run is high. The counter sits at 0 while i_free_run is low, so a
// rising edge of i_free_run always starts a full period.
//   clk, reset  : clock, asynchronous active-high reset
//   i_free_run  : enables the timer
//   i_period    : period in clk cycles (values below 2 act as 2)
//   o_tick      : one-cycle tick
module ltc2333_period_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_free_run,
  input  logic [15:0] i_period,
  output logic        o_tick
);

  logic [15:0] r_cnt;
  logic [15:0] w_period_eff;

  assign w_period_eff = (i_period < 16'd2) ? 16'd2 : i_period;
  // >= rather than == so a period shortened mid-count still wraps promptly
  assign o_tick = i_free_run && (r_cnt >= (w_period_eff - 16'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!i_free_run || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/ltc2333_drive.sv
// ltc2333_drive
// Conversion sequencer for the LTC2333: pulses CNV, waits out the conversion,
// then clocks N_SCK SCKI periods while shifting a per-slot control word onto
// SDI. Slots cycle through seq_cfg over seq_len entries.
//   clk, reset     : clock, asynchronous active-high reset
//   enable         : permits new requests (never aborts a running conversion)
//   start          : single-cycle conversion request
//   free_run       : requests from the internal period timer
//   period         : free-run period in cycles
//   seq_cfg        : eight control words, slot k at [8k+7:8k]
//   seq_len        : active slot count, clamped to 1..8
//   adc            : cnv / scki / sdi pins (master modport)
//   busy, done     : not-idle flag, end-of-conversion pulse
//   slot           : slot of the current / most recent conversion
//   overrun_cnt    : saturating count of dropped requests
module ltc2333_drive
  import ltc2333_pkg::*;
#(
  parameter int CNV_HIGH  = DEF_CNV_HIGH,
  parameter int CONV_WAIT = DEF_CONV_WAIT,
  parameter int SCK_HALF  = DEF_SCK_HALF,
  parameter int N_SCK     = DEF_N_SCK
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   start,
  input  logic                   free_run,
  input  logic [15:0]            period,
  input  logic [63:0]            seq_cfg,
  input  logic [3:0]             seq_len,
  ltc2333_drive_if.master        adc,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             slot,
  output logic [15:0]            overrun_cnt
);

  // One phase counter serves every timed state, so it is sized for the longest
  localparam int PH_W  = $clog2(max3(CNV_HIGH, CONV_WAIT, SCK_HALF) + 1);
  localparam int PER_W = $clog2(N_SCK + 1);
  localparam logic [PH_W-1:0]  CNV_LAST  = PH_W'(CNV_HIGH - 1);
  localparam logic [PH_W-1:0]  CONV_LAST = PH_W'(CONV_WAIT - 1);
  localparam logic [PH_W-1:0]  HALF_LAST = PH_W'(SCK_HALF - 1);
  localparam logic [PER_W-1:0] PER_LAST  = PER_W'(N_SCK - 1);

  state_t           r_state, w_state_next;
  logic [PH_W-1:0]  r_ph, w_ph_next;
  logic [PER_W-1:0] r_per, w_per_next;
  logic             w_enter_lo;
  logic             w_tick, w_req, w_accept, w_drop;
  logic [3:0]       w_len_eff;
  logic [2:0]       w_slot_start;
  logic [7:0]       w_word_bits;
  logic             w_sdi_bit;

  ctrl_word_t  r_word;
  logic [3:0]  r_len;
  logic [2:0]  r_slot;
  logic [15:0] r_overrun;
  logic        r_cnv, r_scki, r_sdi, r_busy, r_done;

  ltc2333_period_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_free_run (free_run),
    .i_period   (period),
    .o_tick     (w_tick)
  );

  // start and a timer tick in the same cycle merge into one request
  assign w_req    = enable && (start || w_tick);
  assign w_accept = w_req && (r_state == IDLE);
  // GAP is not IDLE, so a request on the done cycle is dropped here too
  assign w_drop   = w_req && (r_state != IDLE);

  assign w_len_eff    = (seq_len == 4'd0) ? 4'd1 : ((seq_len > 4'd8) ? 4'd8 : seq_len);
  assign w_slot_start = ({1'b0, r_slot} >= w_len_eff) ? 3'd0 : r_slot;

  assign w_word_bits = r_word;
  assign w_sdi_bit   = (int'(w_per_next) < 8) ? w_word_bits[3'(7 - int'(w_per_next))] : 1'b0;

  always_comb begin
    w_state_next = r_state;
    w_ph_next    = r_ph + 1'b1;
    w_per_next   = r_per;
    w_enter_lo   = 1'b0;
    case (r_state)
      IDLE: begin
        w_ph_next  = '0;
        w_per_next = '0;
        if (w_accept) w_state_next = CNV;
      end
      CNV: begin
        if (r_ph == CNV_LAST) begin
          w_state_next = CONV;
          w_ph_next    = '0;
        end
      end
      CONV: begin
        if (r_ph == CONV_LAST) begin
          w_state_next = SCK_LO;
          w_ph_next    = '0;
          w_enter_lo   = 1'b1;
        end
      end
      SCK_LO: begin
        if (r_ph == HALF_LAST) begin
          w_state_next = SCK_HI;
          w_ph_next    = '0;
        end
      end
      SCK_HI: begin
        if (r_ph == HALF_LAST) begin
          w_ph_next = '0;
          if (r_per == PER_LAST) begin
            w_state_next = GAP;
          end else begin
            w_state_next = SCK_LO;
            w_per_next   = r_per + 1'b1;
            w_enter_lo   = 1'b1;
          end
        end
      end
      GAP: begin
        w_state_next = IDLE;
        w_ph_next    = '0;
      end
      default: begin
        w_state_next = IDLE;
        w_ph_next    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ph    <= '0;
      r_per   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ph    <= w_ph_next;
      r_per   <= w_per_next;
    end
  end

  // Pin registers are decoded from the next state so each pin changes on the
  // same edge as the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnv  <= 1'b0;
      r_scki <= 1'b0;
      r_sdi  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_cnv  <= (w_state_next == CNV);
      r_scki <= (w_state_next == SCK_HI);
      r_busy <= (w_state_next != IDLE);
      r_done <= (w_state_next == GAP);
      if (w_enter_lo) r_sdi <= w_sdi_bit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word    <= '0;
      r_len     <= 4'd1;
      r_slot    <= 3'd0;
      r_overrun <= 16'd0;
    end else begin
      if (w_accept) begin
        r_len  <= w_len_eff;
        r_slot <= w_slot_start;
        r_word <= ctrl_word_t'(seq_cfg[{w_slot_start, 3'b000} +: 8]);
      end else if (r_state == GAP) begin
        r_slot <= ({1'b0, r_slot} >= (r_len - 4'd1)) ? 3'd0 : (r_slot + 3'd1);
      end
      if (w_drop && (r_overrun != 16'hFFFF)) r_overrun <= r_overrun + 16'd1;
    end
  end

  assign adc.cnv     = r_cnv;
  assign adc.scki    = r_scki;
  assign adc.sdi     = r_sdi;
  assign busy        = r_busy;
  assign done        = r_done;
  assign slot        = r_slot;
  assign overrun_cnt = r_overrun;

endmodule

// File: tb/tb_ltc2333_drive.sv
// tb_ltc2333_drive
// Directed bench for ltc2333_drive with default timing (113-cycle conversion).
module tb_ltc2333_drive;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        start = 1'b0;
  logic        free_run = 1'b0;
  logic [15:0] period = 16'd0;
  logic [63:0] seq_cfg = 64'd0;
  logic [3:0]  seq_len = 4'd1;
  logic        busy, done;
  logic [2:0]  slot;
  logic [15:0] overrun_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int done_total = 0;

  ltc2333_drive_if adc_if ();

  ltc2333_drive dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .start       (start),
    .free_run    (free_run),
    .period      (period),
    .seq_cfg     (seq_cfg),
    .seq_len     (seq_len),
    .adc         (adc_if),
    .busy        (busy),
    .done        (done),
    .slot        (slot),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_total++;

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; start = 1'b0; free_run = 1'b0;
    period = 16'd0; seq_cfg = 64'd0; seq_len = 4'd1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge: pulses start now, optionally again at x1/x2, and
  // observes ncyc cycles. Index i is the i-th cycle after the accepting edge.
  task automatic run_conv(input int x1, input int x2, input int ncyc,
                          output int cnv_hi, output int sck_rise, output int sck_hi,
                          output logic [11:0] bits, output int done_at, output int done_n,
                          output int busy_n, output int slot0, output int cnv_rise);
    logic prev_scki, prev_cnv;
    cnv_hi = 0; sck_rise = 0; sck_hi = 0; bits = '0; done_at = -1; done_n = 0;
    busy_n = 0; slot0 = -1; cnv_rise = 0; prev_scki = 1'b0; prev_cnv = 1'b0;
    start = 1'b1;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      start = (i == x1) || (i == x2);
      if (adc_if.cnv) cnv_hi++;
      if (adc_if.cnv && !prev_cnv) cnv_rise++;
      if (adc_if.scki) sck_hi++;
      if (adc_if.scki && !prev_scki) begin
        sck_rise++;
        bits = {bits[10:0], adc_if.sdi};
      end
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      if (busy) busy_n++;
      if (i == 1) slot0 = int'(slot);
      prev_scki = adc_if.scki;
      prev_cnv  = adc_if.cnv;
    end
    start = 1'b0;
    $display("conv: slot=%0d sdi_bits=%h done_at=%0d busy=%0d cnv_hi=%0d overrun=%0d",
             slot0, bits, done_at, busy_n, cnv_hi, overrun_cnt);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (adc_if.cnv !== 1'b0) begin n_fail++; $display("FAIL reset_cnv: got %b expected 0", adc_if.cnv); end
    n_checks++; if (adc_if.scki !== 1'b0) begin n_fail++; $display("FAIL reset_scki: got %b expected 0", adc_if.scki); end
    n_checks++; if (adc_if.sdi !== 1'b0) begin n_fail++; $display("FAIL reset_sdi: got %b expected 0", adc_if.sdi); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (slot !== 3'd0) begin n_fail++; $display("FAIL reset_slot: got %0d expected 0", slot); end
    n_checks++; if (overrun_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_overrun: got %0d expected 0", overrun_cnt); end
  endtask

  task automatic test_single();
    int ch, sr, sh, da, dn, bn, s0, cr;
    logic [11:0] b;
    do_reset();
    seq_len = 4'd1; seq_cfg = 64'h0000_0000_0000_00A5;
    run_conv(0, 0, 130, ch, sr, sh, b, da, dn, bn, s0, cr);
    n_checks++; if (ch != 4) begin n_fail++; $display("FAIL single_cnv_high: got %0d expected 4", ch); end
    n_checks++; if (sr != 12) begin n_fail++; $display("FAIL single_scki_periods: got %0d expected 12", sr); end
    n_checks++; if (sh != 24) begin n_fail++; $display("FAIL single_scki_high_cycles: got %0d expected 24", sh); end
    n_checks++; if (b !== 12'hA50) begin n_fail++; $display("FAIL single_sdi: got %h expected a50", b); end
    n_checks++; if (da != 113) begin n_fail++; $display("FAIL single_done_at: got %0d expected 113", da); end
    n_checks++; if (dn != 1) begin n_fail++; $display("FAIL single_done_count: got %0d expected 1", dn); end
    n_checks++; if (bn != 113) begin n_fail++; $display("FAIL single_busy_len: got %0d expected 113", bn); end
    n_checks++; if (s0 != 0) begin n_fail++; $display("FAIL single_slot: got %0d expected 0", s0); end
    n_checks++; if (slot !== 3'd0) begin n_fail++; $display("FAIL single_slot_after: got %0d expected 0", slot); end
  endtask

  task automatic test_seq_wrap();
    int ch, sr, sh, da, dn, bn, s0, cr;
    logic [11:0] b;
    logic [7:0] words [3];
    int exp_slot;
    words[0] = 8'h81; words[1] = 8'h42; words[2] = 8'hC3;
    do_reset();
    seq_len = 4'd3; seq_cfg = 64'h0000_0000_00C3_4281;
    for (int k = 0; k < 5; k++) begin
      exp_slot = k % 3;
      run_conv(0, 0, 200, ch, sr, sh, b, da, dn, bn, s0, cr);
      n_checks++; if (s0 != exp_slot) begin n_fail++; $display("FAIL wrap_slot[%0d]: got %0d expected %0d", k, s0, exp_slot); end
      n_checks++; if (b !== {words[exp_slot], 4'h0}) begin n_fail++; $display("FAIL wrap_sdi[%0d]: got %h expected %h", k, b, {words[exp_slot], 4'h0}); end
    end
  endtask

  task automatic test_overrun();
    int ch, sr, sh, da, dn, bn, s0, cr;
    logic [11:0] b;
    do_reset();
    seq_cfg = 64'h0000_0000_0000_00A5;
    run_conv(50, 113, 250, ch, sr, sh, b, da, dn, bn, s0, cr);
    n_checks++; if (overrun_cnt !== 16'd2) begin n_fail++; $display("FAIL overrun_cnt: got %0d expected 2", overrun_cnt); end
    n_checks++; if (cr != 1) begin n_fail++; $display("FAIL overrun_conversions: got %0d expected 1", cr); end
    n_checks++; if (dn != 1) begin n_fail++; $display("FAIL overrun_done_count: got %0d expected 1", dn); end
    n_checks++; if (da != 113) begin n_fail++; $display("FAIL overrun_done_at: got %0d expected 113", da); end
  endtask

  task automatic test_free_run();
    int base;
    do_reset();
    period = 16'd150; free_run = 1'b1; base = done_total;
    repeat (1500) @(negedge clk);
    free_run = 1'b0;
    repeat (200) @(negedge clk);
    $display("free_run period=150: conversions=%0d overrun=%0d", done_total - base, overrun_cnt);
    n_checks++; if (done_total - base != 10) begin n_fail++; $display("FAIL free150_conversions: got %0d expected 10", done_total - base); end
    n_checks++; if (overrun_cnt !== 16'd0) begin n_fail++; $display("FAIL free150_overrun: got %0d expected 0", overrun_cnt); end
    do_reset();
    period = 16'd100; free_run = 1'b1; base = done_total;
    repeat (1000) @(negedge clk);
    free_run = 1'b0;
    repeat (200) @(negedge clk);
    $display("free_run period=100: conversions=%0d overrun=%0d", done_total - base, overrun_cnt);
    n_checks++; if (done_total - base != 5) begin n_fail++; $display("FAIL free100_conversions: got %0d expected 5", done_total - base); end
    n_checks++; if (overrun_cnt !== 16'd5) begin n_fail++; $display("FAIL free100_overrun: got %0d expected 5", overrun_cnt); end
  endtask

  task automatic test_reset_mid();
    int ch, sr, sh, da, dn, bn, s0, cr;
    logic [11:0] b;
    do_reset();
    seq_len = 4'd3; seq_cfg = 64'h0000_0000_0000_FFA5;
    run_conv(0, 0, 120, ch, sr, sh, b, da, dn, bn, s0, cr);
    start = 1'b1;
    for (int i = 1; i <= 67; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_checks++; if (adc_if.scki !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_scki: got %b expected 1", adc_if.scki); end
    n_checks++; if (adc_if.sdi !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_sdi: got %b expected 1", adc_if.sdi); end
    #1 reset = 1'b1;
    #1;
    $display("reset mid SCK_HI: cnv=%b scki=%b sdi=%b busy=%b", adc_if.cnv, adc_if.scki, adc_if.sdi, busy);
    n_checks++; if (adc_if.cnv !== 1'b0) begin n_fail++; $display("FAIL midrst_cnv: got %b expected 0", adc_if.cnv); end
    n_checks++; if (adc_if.scki !== 1'b0) begin n_fail++; $display("FAIL midrst_scki: got %b expected 0", adc_if.scki); end
    n_checks++; if (adc_if.sdi !== 1'b0) begin n_fail++; $display("FAIL midrst_sdi: got %b expected 0", adc_if.sdi); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_conv(0, 0, 130, ch, sr, sh, b, da, dn, bn, s0, cr);
    n_checks++; if (bn != 113) begin n_fail++; $display("FAIL midrst_busy_len: got %0d expected 113", bn); end
    n_checks++; if (da != 113) begin n_fail++; $display("FAIL midrst_done_at: got %0d expected 113", da); end
    n_checks++; if (s0 != 0) begin n_fail++; $display("FAIL midrst_slot: got %0d expected 0", s0); end
    n_checks++; if (b !== 12'hA50) begin n_fail++; $display("FAIL midrst_sdi_bits: got %h expected a50", b); end
  endtask

  task automatic test_clamps();
    int ch, sr, sh, da, dn, bn, s0, cr, base, es;
    logic [11:0] b;
    logic [63:0] cfg_v;
    do_reset();
    seq_len = 4'd0; seq_cfg = 64'h0000_0000_0000_993C;
    for (int k = 0; k < 2; k++) begin
      run_conv(0, 0, 120, ch, sr, sh, b, da, dn, bn, s0, cr);
      n_checks++; if (s0 != 0) begin n_fail++; $display("FAIL len0_slot[%0d]: got %0d expected 0", k, s0); end
      n_checks++; if (b !== 12'h3C0) begin n_fail++; $display("FAIL len0_sdi[%0d]: got %h expected 3c0", k, b); end
    end
    do_reset();
    cfg_v = 64'h8877_6655_4433_2211;
    seq_len = 4'd12; seq_cfg = cfg_v;
    for (int k = 0; k < 9; k++) begin
      es = k % 8;
      run_conv(0, 0, 120, ch, sr, sh, b, da, dn, bn, s0, cr);
      n_checks++; if (s0 != es) begin n_fail++; $display("FAIL len12_slot[%0d]: got %0d expected %0d", k, s0, es); end
      n_checks++; if (b !== {cfg_v[8*es +: 8], 4'h0}) begin n_fail++; $display("FAIL len12_sdi[%0d]: got %h expected %h", k, b, {cfg_v[8*es +: 8], 4'h0}); end
    end
    do_reset();
    period = 16'd0; free_run = 1'b1; base = done_total;
    repeat (200) @(negedge clk);
    free_run = 1'b0;
    repeat (150) @(negedge clk);
    $display("free_run period=0: conversions=%0d overrun=%0d", done_total - base, overrun_cnt);
    n_checks++; if (done_total - base != 2) begin n_fail++; $display("FAIL period0_conversions: got %0d expected 2", done_total - base); end
    n_checks++; if (overrun_cnt !== 16'd98) begin n_fail++; $display("FAIL period0_overrun: got %0d expected 98", overrun_cnt); end
  endtask

  task automatic test_enable();
    int ch, sr, sh, da, dn, bn, s0, cr, base;
    logic [11:0] b;
    do_reset();
    enable = 1'b0;
    run_conv(0, 0, 20, ch, sr, sh, b, da, dn, bn, s0, cr);
    n_checks++; if (cr != 0) begin n_fail++; $display("FAIL enable_low_conversions: got %0d expected 0", cr); end
    n_checks++; if (overrun_cnt !== 16'd0) begin n_fail++; $display("FAIL enable_low_overrun: got %0d expected 0", overrun_cnt); end
    enable = 1'b1; start = 1'b1; base = done_total;
    @(negedge clk);
    start = 1'b0; enable = 1'b0;
    repeat (130) @(negedge clk);
    $display("enable dropped mid-conversion: conversions=%0d", done_total - base);
    n_checks++; if (done_total - base != 1) begin n_fail++; $display("FAIL enable_no_abort: got %0d expected 1", done_total - base); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_seq_wrap();
    test_overrun();
    test_free_run();
    test_reset_mid();
    test_clamps();
    test_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
